// File: rtl/tile_pixel_gen.sv
// Tile-based pixel generator: hCount/vCount -> tile-map word -> glyph texel -> RGB888.
// Ports: clk, reset (sync, active-high), bright, hCount, vCount in;
//   tileAddress/tileData and glyphAddress/glyphData are two 1-cycle registered read ports;
//   VGA_R/G/B are registered 8-bit colour outputs, valid 3 edges after the inputs.
module tile_pixel_gen #(
   parameter int unsigned TILE_LOG2     = 2,
   parameter int unsigned TILES_PER_ROW = 160,
   parameter int unsigned TILEMAP_BASE  = 40000,
   parameter int unsigned GLYPH_BASE    = 60000,
   parameter int unsigned GLYPH_COUNT   = 64,
   parameter logic [15:0] ERR_RGB565    = 16'hF81F
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        bright,
   input  logic [15:0] hCount,
   input  logic [15:0] vCount,
   output logic [15:0] tileAddress,
   input  logic [15:0] tileData,
   output logic [15:0] glyphAddress,
   input  logic [15:0] glyphData,
   output logic [7:0]  VGA_R,
   output logic [7:0]  VGA_G,
   output logic [7:0]  VGA_B
);

   localparam int unsigned PXW = 2 * TILE_LOG2;

   localparam logic [15:0] MAP_BASE = 16'(TILEMAP_BASE);
   localparam logic [15:0] GLY_BASE = 16'(GLYPH_BASE);
   localparam logic [15:0] STRIDE   = 16'(TILES_PER_ROW);
   // One extra bit so a count of 65536 still compares correctly.
   localparam logic [16:0] GCOUNT   = 17'(GLYPH_COUNT);

   logic           s1_bright_q, s1_bright_d;
   logic [PXW-1:0] s1_px_q, s1_px_d;
   logic           s2_bright_q, s2_bright_d;
   logic           s2_inv_q, s2_inv_d;
   logic [7:0]     r_q, r_d;
   logic [7:0]     g_q, g_d;
   logic [7:0]     b_q, b_d;

   logic [15:0] row_idx;
   logic [15:0] col_idx;
   logic [15:0] row_off;
   logic [15:0] glyph_off;
   logic        code_inv;
   logic [15:0] texel;

   always_comb begin
      // Stage 0: tile-map address, products truncated to 16 bits.
      row_idx     = vCount >> TILE_LOG2;
      col_idx     = hCount >> TILE_LOG2;
      row_off     = row_idx * STRIDE;
      tileAddress = MAP_BASE + row_off + col_idx;

      // Pixel offset inside the tile: row-major, T texels per row.
      s1_px_d     = {vCount[TILE_LOG2-1:0], hCount[TILE_LOG2-1:0]};
      s1_bright_d = bright;

      // Stage 1: glyph address; invalid codes read the harmless base word.
      code_inv     = {1'b0, tileData} >= GCOUNT;
      glyph_off    = tileData << PXW;
      glyphAddress = code_inv ? GLY_BASE
                              : GLY_BASE + glyph_off + 16'(s1_px_q);
      s2_bright_d  = s1_bright_q;
      s2_inv_d     = code_inv;

      // Stage 2: RGB565 -> RGB888 by MSB replication.
      texel = s2_inv_q ? ERR_RGB565 : glyphData;
      r_d   = 8'h00;
      g_d   = 8'h00;
      b_d   = 8'h00;
      if (s2_bright_q) begin
         r_d = {texel[15:11], texel[15:13]};
         g_d = {texel[10:5],  texel[10:9]};
         b_d = {texel[4:0],   texel[4:2]};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_bright_q <= 1'b0;
         s1_px_q     <= '0;
         s2_bright_q <= 1'b0;
         s2_inv_q    <= 1'b0;
         r_q         <= 8'h00;
         g_q         <= 8'h00;
         b_q         <= 8'h00;
      end else begin
         s1_bright_q <= s1_bright_d;
         s1_px_q     <= s1_px_d;
         s2_bright_q <= s2_bright_d;
         s2_inv_q    <= s2_inv_d;
         r_q         <= r_d;
         g_q         <= g_d;
         b_q         <= b_d;
      end
   end

   assign VGA_R = r_q;
   assign VGA_G = g_q;
   assign VGA_B = b_q;

endmodule

// File: tb/tb_tile_pixel_gen.sv
// Scoreboard bench for tile_pixel_gen: registered memory model feeds the DUT,
// expected RGB pushed at drive time and popped when the output is due.
module tb_tile_pixel_gen;

   logic        clk = 1'b0;
   logic        reset;
   logic        bright;
   logic [15:0] hCount, vCount;
   logic [15:0] tileAddress, tileData;
   logic [15:0] glyphAddress, glyphData;
   logic [7:0]  VGA_R, VGA_G, VGA_B;

   logic [15:0] h2, v2, td2;
   logic [15:0] ta2, ga2;
   logic [7:0]  r2, g2, b2;

   logic [15:0] tile_mem  [65536];
   logic [15:0] glyph_mem [65536];

   int n_tests = 0;
   int n_fail  = 0;
   int q[$];

   always #5 clk = ~clk;

   tile_pixel_gen u_dut (
      .clk          (clk),
      .reset        (reset),
      .bright       (bright),
      .hCount       (hCount),
      .vCount       (vCount),
      .tileAddress  (tileAddress),
      .tileData     (tileData),
      .glyphAddress (glyphAddress),
      .glyphData    (glyphData),
      .VGA_R        (VGA_R),
      .VGA_G        (VGA_G),
      .VGA_B        (VGA_B)
   );

   tile_pixel_gen #(.TILE_LOG2(3), .TILES_PER_ROW(80)) u_dut8 (
      .clk          (clk),
      .reset        (reset),
      .bright       (1'b0),
      .hCount       (h2),
      .vCount       (v2),
      .tileAddress  (ta2),
      .tileData     (td2),
      .glyphAddress (ga2),
      .glyphData    (16'h0000),
      .VGA_R        (r2),
      .VGA_G        (g2),
      .VGA_B        (b2)
   );

   // Registered read ports, one cycle of latency.
   always @(posedge clk) begin
      tileData  <= tile_mem[tileAddress];
      glyphData <= glyph_mem[glyphAddress];
   end

   task automatic chk(input string tag, input int got, input int exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                  tag, got, got, exp, exp);
      end
   endtask

   function automatic int m_ta(input int h, input int v);
      return (40000 + ((v >> 2) * 160) + (h >> 2)) & 16'hFFFF;
   endfunction

   function automatic int m_ga(input int h, input int v);
      int code;
      code = int'(tile_mem[m_ta(h, v)]);
      if (code >= 64) return 60000;
      return (60000 + code * 16 + (v % 4) * 4 + (h % 4)) & 16'hFFFF;
   endfunction

   function automatic int m_rgb(input int h, input int v, input bit b);
      logic [15:0] t;
      int code;
      if (!b) return 0;
      code = int'(tile_mem[m_ta(h, v)]);
      if (code >= 64) t = 16'hF81F;
      else t = glyph_mem[m_ga(h, v)];
      return int'({t[15:11], t[15:13], t[10:5], t[10:9], t[4:0], t[4:2]});
   endfunction

   task automatic step(input int h, input int v, input bit b, input bit r,
                       input int ta_k = -1, input int ga_k = -1,
                       input int rgb_k = -1);
      int ga_e;
      hCount = 16'(h);
      vCount = 16'(v);
      bright = b;
      reset  = r;
      if (r) begin
         foreach (q[i]) q[i] = 0;
         q.push_back(0);
      end else if (rgb_k >= 0) q.push_back(rgb_k);
      else q.push_back(m_rgb(h, v, b));
      #1;
      chk("tile_addr", int'(tileAddress), m_ta(h, v));
      if (ta_k >= 0) chk("tile_addr_k", int'(tileAddress), ta_k);
      ga_e = m_ga(h, v);
      @(posedge clk);
      #1;
      if (q.size() == 3)
         chk("rgb", int'({VGA_R, VGA_G, VGA_B}), q.pop_front());
      if (!r) chk("glyph_addr", int'(glyphAddress), ga_e);
      if (ga_k >= 0) chk("glyph_addr_k", int'(glyphAddress), ga_k);
   endtask

   initial begin
      reset  = 1'b1;
      bright = 1'b0;
      hCount = '0;
      vCount = '0;
      h2     = '0;
      v2     = '0;
      td2    = '0;
      for (int i = 0; i < 65536; i++) begin
         tile_mem[i]  = 16'($urandom_range(0, 79));
         glyph_mem[i] = 16'($urandom);
      end
      tile_mem[40161]  = 16'd4;
      tile_mem[40162]  = 16'd64;
      glyph_mem[60073] = 16'hFFFF;
      glyph_mem[60074] = 16'h001F;
      glyph_mem[60075] = 16'h8410;

      @(posedge clk);
      #1;

      // Reset with bright high: output stays black.
      for (int i = 0; i < 4; i++) step(0, 0, 1'b1, 1'b1);

      // Directed addresses and colour expansion.
      step(5, 6, 1'b1, 1'b0, 40161, 60073, 24'hFFFFFF);
      step(6, 6, 1'b1, 1'b0, -1, 60074, 24'h0000FF);
      step(7, 6, 1'b1, 1'b0, -1, 60075, 24'h848284);
      // Invalid glyph code -> magenta, harmless base read.
      step(8, 6, 1'b1, 1'b0, -1, 60000, 24'hFF00FF);
      step(11, 6, 1'b1, 1'b0, -1, 60000, 24'hFF00FF);

      // Raster sweep, one-pixel bright dropout mid-line.
      for (int h = 0; h < 48; h++) step(h, 10, (h != 21), 1'b0);

      // Reset held two cycles mid-line.
      for (int h = 0; h < 40; h++) step(h, 11, 1'b1, (h == 17 || h == 18));

      // Counters past the visible area wrap.
      step(65535, 65535, 1'b1, 1'b0);
      step(1000, 4000, 1'b1, 1'b0);
      step(800, 525, 1'b1, 1'b0);
      step(3, 0, 1'b1, 1'b0);
      step(4, 0, 1'b1, 1'b0);

      // Drain the pipeline.
      for (int i = 0; i < 3; i++) step(0, 0, 1'b0, 1'b0);

      // TILE_LOG2 = 3 instance.
      h2  = 16'd15;
      v2  = 16'd8;
      #1;
      chk("t8_tile_addr", int'(ta2), 40081);
      @(posedge clk);
      td2 = 16'd2;
      #1;
      chk("t8_glyph_addr", int'(ga2), 60135);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/tile_pixel_gen.md
Name: tile_pixel_gen

Overview:
Parametrised, pipelined tile-based pixel generator for the VGA path. Each pixel is produced in three steps:
- Map the current hCount/vCount to a tile-map word.
- Read a glyph index from that word.
- Fetch the RGB565 texel for that pixel from the glyph bitmap region and expand it to 8-bit R/G/B.

It sits between the VGA timing counter and the VGA DAC. It reads shared memory through two registered read ports (tile port and glyph port, each with 1-cycle latency).

Parameters:
TILE_LOG2  2  log2 of tile edge in pixels (tile = 2^TILE_LOG2 square)
TILES_PER_ROW  160  tiles per screen row (tile-map stride)
TILEMAP_BASE  40000  16-bit word address of tile-map entry (0,0)
GLYPH_BASE  60000  16-bit word address of glyph 0, texel 0
GLYPH_COUNT  64  number of valid glyph indices; codes >= GLYPH_COUNT are invalid
ERR_RGB565  16'hF81F  texel substituted for invalid glyph codes (magenta)

Ports:
clk  in  1  system clock, one pixel per cycle
reset  in  1  synchronous, active-high
bright  in  1  visible-area flag, aligned with hCount/vCount
hCount  in  16  current pixel column
vCount  in  16  current pixel row
tileAddress  out  16  tile-map read address (combinational from inputs)
tileData  in  16  tile-map word, valid 1 cycle after tileAddress
glyphAddress  out  16  glyph bitmap read address (combinational from stage-1 regs + tileData)
glyphData  in  16  RGB565 texel, valid 1 cycle after glyphAddress
VGA_R  out  8  red, registered
VGA_G  out  8  green, registered
VGA_B  out  8  blue, registered

Behaviour:
- Let T = 2^TILE_LOG2. All address arithmetic is unsigned 16-bit and wraps modulo 2^16. Intermediate products are truncated to 16 bits.
- Stage 0 (comb):
  - tileAddress = TILEMAP_BASE + (vCount>>TILE_LOG2)*TILES_PER_ROW + (hCount>>TILE_LOG2).
  - Shift is applied before add; no precedence ambiguity.
- Stage 1 regs (clock edge after stage 0):
  - s1_bright <= bright.
  - s1_px <= (vCount mod T)*T + (hCount mod T), width 2*TILE_LOG2.
- Stage 1 (comb), using code = tileData:
  - Invalid when code >= GLYPH_COUNT.
  - glyphAddress = GLYPH_BASE + code*T*T + s1_px when valid, else GLYPH_BASE (a harmless read).
- Stage 2 regs:
  - s2_bright <= s1_bright.
  - s2_inv <= (code >= GLYPH_COUNT).
- Stage 2 → output regs:
  - texel = s2_inv ? ERR_RGB565 : glyphData.
  - If s2_bright: VGA_R <= {t[15:11], t[15:13]}; VGA_G <= {t[10:5], t[10:9]}; VGA_B <= {t[4:0], t[4:2]} (MSB replication, so full-scale 565 maps to 255).
  - Else all three outputs <= 0.
- Latency: inputs at cycle n produce RGB at the output register after edge n+3. Fixed and independent of data, with no stalls. The timing generator delays hsync/vsync by 3 cycles to match.
- No handshake: the memory ports must return data exactly 1 cycle after the address every cycle.
- Reset (synchronous):
  - Clears s1_bright, s2_bright, s2_inv, s1_px and VGA_R/G/B to 0.
  - Outputs remain black for the first 3 cycles after reset deasserts, even if bright = 1.
  - Reset asserted mid-frame blanks output on the next edge; no partial pixel escapes.
- bright deasserted: the address ports still toggle (don't care); output is black exactly 3 cycles later.
- Boundary cases:
  - hCount/vCount past the visible area still produce wrapped addresses; no error.
  - Tile edges: hCount = k*T-1 → k*T switches tile address in the same cycle, with no lag.
- Bit-exact requirement: memData values 0/1/2 etc. are glyph indices, not colours. Solid-colour glyphs are plain bitmaps in glyph memory.

Test Plan:
1. Defaults, hCount=5, vCount=6 → tileAddress = 40000+1*160+1 = 40161. With tileData=4 next cycle, glyphAddress = 60000+64+(2*4+1) = 60073.
2. Defaults, bright=1, glyphData=16'hFFFF → VGA_R/G/B = 255/255/255 exactly 3 edges after inputs. glyphData=16'h001F → 0/0/255. glyphData=16'h8410 → 132/130/132.
3. tileData=64 (>= GLYPH_COUNT), bright=1 → glyphAddress=60000; output 255/0/255 regardless of glyphData.
4. Raster sweep: bright pulsed low for one pixel mid-line → exactly one black output pixel, 3 cycles later; neighbouring pixels unaffected.
5. reset held 2 cycles mid-line with bright=1 and white texels → outputs 0 on the first reset edge; 0 for 3 edges after release, then white.
6. TILE_LOG2=3, TILES_PER_ROW=80, hCount=15, vCount=8 → tileAddress = 40000+80+1 = 40081. With tileData=2, glyphAddress = 60000+128+(0*8+7) = 60135.
